accfifo_drain_ctrl: RTL and testbench
=====================================

# accfifo_drain_ctrl

Drain controller that sits directly downstream of the double-buffered accumulator FIFO pair. On each tile completion it swaps the compute and shadow FIFO roles by driving `which_fifo_to_compute`. It then empties the shadow FIFO into the global buffer over a valid/ready write port, with sequential addresses from a per-tile base. It also stalls the compute side when a new swap is requested before the previous drain has finished.

## Interface
Parameters:
- `output_width`, 24: width of one accumulator word, equal to the FIFO data width.
- `nb_data`, 32: FIFO depth; it bounds the words drained per tile.
- `ADDR_W`, 16: global buffer address width.

Ports:
- `clk`  in  1  single clock for the block.
- `rst_n`  in  1  asynchronous, active-low reset.
- `tile_done`  in  1  one-cycle pulse. The compute FIFO holds a complete tile.
- `tile_base_addr`  in  ADDR_W  global buffer base for that tile; sampled with `tile_done`.
- `which_fifo_to_compute`  out  1  selects which FIFO is the compute FIFO; drives the FIFO pair.
- `shadow_fifo_read`  out  1  read strobe to the shadow FIFO.
- `shadow_fifo_data_out`  in  output_width  shadow FIFO data; valid the cycle after a read.
- `shadow_fifo_empty`  in  1  shadow FIFO empty flag; reflects all reads issued before the current cycle.
- `gb_wr_valid`  out  1  a write request is pending.
- `gb_wr_ready`  in  1  the global buffer accepts the write.
- `gb_wr_data`  out  output_width  write data.
- `gb_wr_addr`  out  ADDR_W  write address.
- `swap_stall`  out  1  the compute side must not write or signal `tile_done`.
- `drain_busy`  out  1  the FSM is not in IDLE.
- `drain_done`  out  1  one-cycle pulse when a tile is fully written.
- `pend_overflow`  out  1  sticky flag; set when a `tile_done` is dropped.

## Operation
- FSM states: IDLE, SWAP, DRAIN.
- IDLE, `tile_done`=1:
  - toggle `which_fifo_to_compute`;
  - latch `tile_base_addr`;
  - clear word index;
  - go to SWAP.
- SWAP lasts one cycle so the FIFO muxes settle. No read is issued. Next state is DRAIN.
- DRAIN read rule: assert `shadow_fifo_read` iff all of the following hold:
  - `shadow_fifo_empty`=0;
  - (output queue occupancy + reads in flight) < 2.
- Read data is captured into a 2-entry output FIFO exactly one cycle after the read.
- The head of the output FIFO drives `gb_wr_data`. `gb_wr_valid` = queue not empty.
- `gb_wr_addr` = latched base + word index, truncated to ADDR_W, so it wraps modulo 2^ADDR_W.
- The word index increments on each `gb_wr_valid & gb_wr_ready`.
- DRAIN exits when all of these hold: `shadow_fifo_empty`=1, no read in flight, queue empty, no handshake this cycle.
  - On exit, pulse `drain_done`.
  - If a tile is pending, go to SWAP: toggle, latch the pending base, clear the index.
  - Otherwise go to IDLE.
- `tile_done` while not IDLE:
  - if no tile is pending, record one pending tile and its base address;
  - if one is already pending, drop the new one and set `pend_overflow`.
- `swap_stall` = pending tile recorded, or (`tile_done` arriving while not IDLE).
- A tile with zero words: SWAP, then DRAIN exits on the first DRAIN cycle with a `drain_done` pulse.
- `gb_wr_data` and `gb_wr_addr` stay stable while `gb_wr_valid`=1 and `gb_wr_ready`=0.

## Timing
- Reset (async assert): state IDLE, `which_fifo_to_compute`=0, `shadow_fifo_read`=0, `gb_wr_valid`=0, `gb_wr_data`=0, `gb_wr_addr`=0.
- Reset also clears the index, `swap_stall`, `drain_busy`, `drain_done`, `pend_overflow`, the pending state and the queue.
- Reset mid-drain discards queued and in-flight data. Reads issued before reset are not replayed.
- Cycle sequence from `tile_done`:
  - t0: `tile_done`;
  - t1: SWAP, with `which_fifo_to_compute` toggled;
  - t2: first `shadow_fifo_read`;
  - t3: data captured;
  - t4: first `gb_wr_valid`.
- Steady-state throughput with `gb_wr_ready`=1: one word per cycle.
- `drain_busy` is asserted from t1 through the `drain_done` cycle inclusive.
- `drain_done` is registered and high for exactly one cycle.
- `tile_done` in the same cycle as a DRAIN exit counts as pending and is served by the direct DRAIN→SWAP transition.

## Test plan
- Reset, then `tile_done` with base 0x0100, shadow FIFO holding 4 words A..D, ready=1. Required: toggle at t1; writes A..D to 0x0100..0x0103 on cycles t4..t7; `drain_done` at the exit cycle.
- Same tile with `gb_wr_ready` toggling 1,0,0,1… Required: all 4 words in order; data and address stable while stalled; never more than 2 reads outstanding; no word lost or duplicated.
- Second `tile_done` (base 0x0200) mid-drain. Required: `swap_stall`=1 until the second SWAP; direct DRAIN→SWAP; `which_fifo_to_compute` toggles twice in total; second tile written from 0x0200.
- Third `tile_done` while one is already pending. Required: `pend_overflow`=1 and stays set; only two tiles are drained.
- Base 0xFFFE with 4 words. Required: addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001.
- Empty-shadow tile, and a separate case with `rst_n` dropped mid-drain. Required for the empty tile: `drain_done` 2 cycles after SWAP with no writes. Required for the reset: immediate reset values on all outputs, and IDLE.

Source files
------------

// File: rtl/accfifo_drain_ctrl_if.sv
// accfifo_drain_ctrl_if
//   Bundles the signals between the drain controller, the accumulator FIFO
//   pair, the compute side and the global buffer write port.
//   master : drain controller side (drives FIFO select, read strobe, GB write,
//            status flags).
//   slave  : environment side (compute tile_done/base, shadow FIFO data/empty,
//            GB ready).
interface accfifo_drain_ctrl_if #(
  parameter int output_width = 24,
  parameter int ADDR_W       = 16
);
  logic                    tile_done;
  logic [ADDR_W-1:0]       tile_base_addr;
  logic                    which_fifo_to_compute;
  logic                    shadow_fifo_read;
  logic [output_width-1:0] shadow_fifo_data_out;
  logic                    shadow_fifo_empty;
  logic                    gb_wr_valid;
  logic                    gb_wr_ready;
  logic [output_width-1:0] gb_wr_data;
  logic [ADDR_W-1:0]       gb_wr_addr;
  logic                    swap_stall;
  logic                    drain_busy;
  logic                    drain_done;
  logic                    pend_overflow;

  modport master (
    input  tile_done, tile_base_addr, shadow_fifo_data_out, shadow_fifo_empty,
           gb_wr_ready,
    output which_fifo_to_compute, shadow_fifo_read, gb_wr_valid, gb_wr_data,
           gb_wr_addr, swap_stall, drain_busy, drain_done, pend_overflow
  );

  modport slave (
    output tile_done, tile_base_addr, shadow_fifo_data_out, shadow_fifo_empty,
           gb_wr_ready,
    input  which_fifo_to_compute, shadow_fifo_read, gb_wr_valid, gb_wr_data,
           gb_wr_addr, swap_stall, drain_busy, drain_done, pend_overflow
  );
endinterface

// File: rtl/accfifo_drain_ctrl.sv
// accfifo_drain_ctrl
//   Drains the shadow half of a double-buffered accumulator FIFO pair into the
//   global buffer. On tile_done the compute/shadow roles swap, then the shadow
//   FIFO is read out through a 2-entry output queue onto a valid/ready write
//   port at sequential addresses from the tile base. A second tile arriving
//   mid-drain is held as pending (compute side stalled); a third is dropped
//   and flagged sticky in pend_overflow.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   io_drn     : master modport of accfifo_drain_ctrl_if (tile handshake,
//                shadow FIFO read side, GB write port, status flags)
module accfifo_drain_ctrl #(
  parameter int output_width = 24,
  parameter int nb_data      = 32,
  parameter int ADDR_W       = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  accfifo_drain_ctrl_if.master        io_drn
);
  localparam int IDX_W = $clog2(nb_data + 1);

  typedef enum logic [1:0] {S_IDLE, S_SWAP, S_DRAIN} state_t;

  state_t                        r_state, w_state_nxt;
  logic                          r_which;
  logic [ADDR_W-1:0]             r_base;
  logic [IDX_W-1:0]              r_idx;
  logic                          r_inflight;
  logic                          r_done;
  logic                          r_pend;
  logic [ADDR_W-1:0]             r_pend_base;
  logic                          r_ovf;
  logic [1:0][output_width-1:0]  r_q;
  logic                          r_q_rd, r_q_wr;
  logic [1:0]                    r_q_cnt;

  logic                          w_pop, w_push, w_rd, w_exit, w_swap_ld, w_td_busy;
  logic [ADDR_W-1:0]             w_ld_base;
  logic [1:0]                    w_q_after_pop;

  assign w_pop         = (r_q_cnt != 2'd0) & io_drn.gb_wr_ready;
  assign w_push        = r_inflight;
  assign w_q_after_pop = r_q_cnt - {1'b0, w_pop};
  assign w_td_busy     = io_drn.tile_done & (r_state != S_IDLE);

  // Next state and control strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_rd        = 1'b0;
    w_exit      = 1'b0;
    w_swap_ld   = 1'b0;
    w_ld_base   = io_drn.tile_base_addr;
    case (r_state)
      S_IDLE: begin
        if (io_drn.tile_done) begin
          w_swap_ld   = 1'b1;
          w_state_nxt = S_SWAP;
        end
      end
      S_SWAP: w_state_nxt = S_DRAIN;
      S_DRAIN: begin
        // Occupancy is counted after this cycle's pop so a word leaving the
        // queue frees its slot immediately: one word per cycle at ready=1.
        w_rd   = ~io_drn.shadow_fifo_empty &
                 ((w_q_after_pop + {1'b0, r_inflight}) < 2'd2);
        w_exit = io_drn.shadow_fifo_empty & ~r_inflight &
                 (r_q_cnt == 2'd0) & ~w_pop;
        if (w_exit) begin
          if (r_pend) begin
            w_swap_ld   = 1'b1;
            w_ld_base   = r_pend_base;
            w_state_nxt = S_SWAP;
          end else if (io_drn.tile_done) begin
            // tile_done on the exit cycle is served directly
            w_swap_ld   = 1'b1;
            w_state_nxt = S_SWAP;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_which     <= 1'b0;
      r_base      <= '0;
      r_idx       <= '0;
      r_inflight  <= 1'b0;
      r_done      <= 1'b0;
      r_pend      <= 1'b0;
      r_pend_base <= '0;
      r_ovf       <= 1'b0;
      r_q         <= '0;
      r_q_rd      <= 1'b0;
      r_q_wr      <= 1'b0;
      r_q_cnt     <= '0;
    end else begin
      r_inflight <= w_rd;
      r_done     <= w_exit;

      if (w_swap_ld) begin
        r_which <= ~r_which;
        r_base  <= w_ld_base;
        r_idx   <= '0;
      end else if (w_pop) begin
        r_idx   <= r_idx + 1'b1;
      end

      // One pending slot; a tile_done that finds it occupied is lost.
      if (w_td_busy & r_pend) r_ovf <= 1'b1;
      if (w_exit) begin
        r_pend <= 1'b0;
      end else if (w_td_busy & ~r_pend) begin
        r_pend      <= 1'b1;
        r_pend_base <= io_drn.tile_base_addr;
      end

      // Shadow FIFO data is valid the cycle after the read strobe.
      if (w_push) begin
        r_q[r_q_wr] <= io_drn.shadow_fifo_data_out;
        r_q_wr      <= ~r_q_wr;
      end
      if (w_pop) r_q_rd <= ~r_q_rd;
      r_q_cnt <= r_q_cnt + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

  assign io_drn.which_fifo_to_compute = r_which;
  assign io_drn.shadow_fifo_read      = w_rd;
  assign io_drn.gb_wr_valid           = (r_q_cnt != 2'd0);
  assign io_drn.gb_wr_data            = r_q[r_q_rd];
  assign io_drn.gb_wr_addr            = r_base + ADDR_W'(r_idx);
  assign io_drn.swap_stall            = r_pend | w_td_busy;
  // Held through the drain_done cycle even though the FSM is already back.
  assign io_drn.drain_busy            = (r_state != S_IDLE) | r_done;
  assign io_drn.drain_done            = r_done;
  assign io_drn.pend_overflow         = r_ovf;

endmodule

// File: tb/tb_accfifo_drain_ctrl.sv
// tb_accfifo_drain_ctrl
//   Directed timing cases plus randomized tiles. The bench models the FIFO
//   pair as two queues, keeps a queue of expected (addr, data) writes per
//   tile, and checks every GB handshake against it.
module tb_accfifo_drain_ctrl;
  localparam int W  = 24;
  localparam int AW = 16;
  typedef logic [31:0] u32;
  typedef struct { logic [AW-1:0] addr; logic [W-1:0] data; } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  accfifo_drain_ctrl_if #(.output_width(W), .ADDR_W(AW)) bus ();

  accfifo_drain_ctrl #(.output_width(W), .nb_data(32), .ADDR_W(AW)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .io_drn (bus)
  );

  int n_chk = 0, n_fail = 0;
  logic [W-1:0] fq0[$], fq1[$];
  exp_t exp_q[$];
  int outst = 0, wr_cnt = 0, tg_cnt = 0, d_cnt = 0;
  u32 s_rd, s_vld, s_data, s_addr, s_which, s_stall, s_busy, s_done, s_ovf;
  u32 p_which = 0, p_data = 0, p_addr = 0;
  logic p_stall = 1'b0;

  task automatic chk(input string tag, input u32 got, input u32 exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int fsize(logic s);
    return s ? fq1.size() : fq0.size();
  endfunction
  function automatic logic [W-1:0] fpop(logic s);
    if (s) return fq1.pop_front();
    return fq0.pop_front();
  endfunction
  function automatic void fpush(logic s, logic [W-1:0] d);
    if (s) fq1.push_back(d); else fq0.push_back(d);
  endfunction

  // Compute side: fill the compute FIFO with n words, then pulse tile_done.
  task automatic send_tile(input logic [AW-1:0] base, input int n);
    logic c; logic [W-1:0] d; exp_t e;
    c = bus.which_fifo_to_compute;
    for (int i = 0; i < n; i++) begin
      d = W'($urandom);
      fpush(c, d);
      e.addr = base + AW'(i);
      e.data = d;
      exp_q.push_back(e);
    end
    bus.tile_base_addr = base;
    bus.tile_done      = 1'b1;
  endtask

  // One clock cycle; entered and left at the falling edge.
  task automatic tick();
    logic sh; logic [W-1:0] d_nxt; exp_t e;
    sh = ~bus.which_fifo_to_compute;
    bus.shadow_fifo_empty = (fsize(sh) == 0);
    #1;
    s_rd = u32'(bus.shadow_fifo_read);   s_vld   = u32'(bus.gb_wr_valid);
    s_data = u32'(bus.gb_wr_data);       s_addr  = u32'(bus.gb_wr_addr);
    s_which = u32'(bus.which_fifo_to_compute);
    s_stall = u32'(bus.swap_stall);      s_busy  = u32'(bus.drain_busy);
    s_done = u32'(bus.drain_done);       s_ovf   = u32'(bus.pend_overflow);
    if (s_which != p_which) tg_cnt++;
    p_which = s_which;
    if (s_done == 1) d_cnt++;
    if (p_stall) begin
      chk("hold_vld", s_vld, 1);
      chk("hold_data", s_data, p_data);
      chk("hold_addr", s_addr, p_addr);
    end
    d_nxt = '0;
    if (s_rd == 1) begin
      if (fsize(sh) == 0) chk("rd_on_empty", 1, 0);
      else d_nxt = fpop(sh);
      outst++;
    end
    if (s_vld == 1 && bus.gb_wr_ready) begin
      wr_cnt++; outst--;
      if (exp_q.size() == 0) chk("wr_extra", 1, 0);
      else begin
        e = exp_q.pop_front();
        chk("wr_addr", s_addr, u32'(e.addr));
        chk("wr_data", s_data, u32'(e.data));
      end
    end
    if (s_rd == 1) chk("outstanding_le2", u32'(outst <= 2), 1);
    p_stall = (s_vld == 1) && !bus.gb_wr_ready;
    p_data  = s_data;
    p_addr  = s_addr;
    @(posedge clk); #1;
    bus.shadow_fifo_data_out = (s_rd == 1) ? d_nxt : W'($urandom);
    bus.tile_done = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_done(input string tag, input int budget);
    int c; c = 0;
    do begin tick(); c++; end while (s_done != 1 && c < budget);
    chk(tag, s_done, 1);
  endtask

  task automatic chk_rst();
    chk("rst_which", u32'(bus.which_fifo_to_compute), 0);
    chk("rst_rd",    u32'(bus.shadow_fifo_read), 0);
    chk("rst_vld",   u32'(bus.gb_wr_valid), 0);
    chk("rst_data",  u32'(bus.gb_wr_data), 0);
    chk("rst_addr",  u32'(bus.gb_wr_addr), 0);
    chk("rst_stall", u32'(bus.swap_stall), 0);
    chk("rst_busy",  u32'(bus.drain_busy), 0);
    chk("rst_done",  u32'(bus.drain_done), 0);
    chk("rst_ovf",   u32'(bus.pend_overflow), 0);
  endtask

  initial begin
    int w0, tg0, d0, sent;
    logic [3:0] pat;
    rst_n = 1'b0;
    bus.tile_done = 1'b0; bus.tile_base_addr = '0;
    bus.shadow_fifo_data_out = '0; bus.shadow_fifo_empty = 1'b1;
    bus.gb_wr_ready = 1'b0;
    #2 chk_rst();
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // Basic 4-word tile at 0x0100, ready=1: cycle-exact timing.
    w0 = wr_cnt;
    send_tile(16'h0100, 4); bus.gb_wr_ready = 1'b1;
    tick(); chk("t0_which", s_which, 0); chk("t0_busy", s_busy, 0);
    tick(); chk("t1_which", s_which, 1); chk("t1_busy", s_busy, 1);
            chk("t1_no_rd", s_rd, 0);
    tick(); chk("t2_rd", s_rd, 1);
    tick(); chk("t3_vld", s_vld, 0);
    for (int k = 0; k < 4; k++) begin
      tick(); chk("t4_7_vld", s_vld, 1); chk("t4_7_addr", s_addr, u32'(32'h100 + k));
    end
    tick(); chk("t8_done", s_done, 0); chk("t8_busy", s_busy, 1);
    tick(); chk("t9_done", s_done, 1); chk("t9_busy", s_busy, 1);
    tick(); chk("t10_done", s_done, 0); chk("t10_busy", s_busy, 0);
    chk("t1_words", u32'(wr_cnt - w0), 4);

    // Same tile with ready toggling 1,0,0,1.
    w0 = wr_cnt; pat = 4'b1001;
    send_tile(16'h0100, 4);
    begin
      int c; c = 0;
      do begin bus.gb_wr_ready = pat[c % 4]; tick(); c++; end
      while (s_done != 1 && c < 60);
      chk("bp_done", s_done, 1);
    end
    bus.gb_wr_ready = 1'b1; tick();
    chk("bp_words", u32'(wr_cnt - w0), 4);
    chk("bp_left", u32'(exp_q.size()), 0);

    // Second tile mid-drain, third while pending (dropped).
    tg0 = tg_cnt; d0 = d_cnt;
    send_tile(16'h0100, 6);
    tick(); tick(); tick(); tick();
    send_tile(16'h0200, 4); tick(); chk("p2_stall", s_stall, 1);
    send_tile(16'h0300, 0); tick(); chk("p3_stall", s_stall, 1);
    tick(); chk("p3_ovf", s_ovf, 1);
    begin
      int c; u32 w; c = 0; w = s_which;
      do begin
        tick(); c++;
        if (s_which == w) chk("pend_stall", s_stall, 1);
        chk("pend_busy", s_busy, 1);
      end while (s_which == w && c < 40);
      chk("direct_swap_done", s_done, 1);
    end
    wait_done("tile2_done", 40);
    tick(); tick(); tick();
    chk("two_swaps", u32'(tg_cnt - tg0), 2);
    chk("two_dones", u32'(d_cnt - d0), 2);
    chk("idle_after", s_busy, 0);
    chk("ovf_sticky", s_ovf, 1);
    chk("pend_left", u32'(exp_q.size()), 0);

    // Address wrap from 0xFFFE.
    w0 = wr_cnt;
    send_tile(16'hFFFE, 4);
    wait_done("wrap_done", 40); tick();
    chk("wrap_words", u32'(wr_cnt - w0), 4);
    chk("wrap_ovf_sticky", s_ovf, 1);

    // Empty shadow FIFO tile.
    w0 = wr_cnt; tg0 = tg_cnt;
    send_tile(16'h0400, 0);
    tick();
    tick(); chk("e_swap", u32'(tg_cnt - tg0), 1); chk("e_busy", s_busy, 1);
    tick(); chk("e_done_t2", s_done, 0); chk("e_rd", s_rd, 0);
    tick(); chk("e_done_t3", s_done, 1); chk("e_vld", s_vld, 0);
    tick(); chk("e_idle", s_busy, 0); chk("e_words", u32'(wr_cnt - w0), 0);

    // Reset mid-drain.
    send_tile(16'h0500, 6);
    for (int k = 0; k < 6; k++) tick();
    #2 rst_n = 1'b0;
    #1 chk_rst();
    fq0.delete(); fq1.delete(); exp_q.delete();
    outst = 0; p_stall = 1'b0; p_which = 0;
    @(negedge clk); rst_n = 1'b1;

    // Randomized tiles obeying swap_stall.
    tg0 = tg_cnt; d0 = d_cnt; sent = 0;
    for (int c = 0; c < 3000; c++) begin
      bus.gb_wr_ready = ($urandom_range(3) != 0);
      if (sent < 60 && !bus.swap_stall && $urandom_range(5) == 0) begin
        send_tile(AW'($urandom), int'($urandom_range(8)));
        sent++;
      end
      tick();
    end
    bus.gb_wr_ready = 1'b1;
    for (int c = 0; c < 200; c++) tick();
    chk("rnd_swaps", u32'(tg_cnt - tg0), u32'(sent));
    chk("rnd_dones", u32'(d_cnt - d0), u32'(sent));
    chk("rnd_left", u32'(exp_q.size()), 0);
    chk("rnd_idle", s_busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog reached @%0t", $time);
    $fatal(1);
  end
endmodule
